// File: rtl/phase_gen.sv
// Machine-cycle phase sequencer: one-hot phase walk with fetch/ALU strobes,
// stall freeze, deferred halt and a wrapping count of completed cycles.
module phase_gen #(
  parameter int NPHASE    = 8,
  parameter int ALU_PHASE = 1,
  parameter int FETCH_ON  = 3,
  parameter int FETCH_OFF = 6,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              stall,
  input  logic              halt,
  output logic              fetch,
  output logic              alu_ena,
  output logic [NPHASE-1:0] phase,
  output logic              cycle_done,
  output logic              idle,
  output logic [CNT_W-1:0]  cycle_cnt
);

  if (NPHASE < 4 || NPHASE > 16 || ALU_PHASE < 0 || ALU_PHASE >= NPHASE ||
      FETCH_ON < 0 || FETCH_ON > FETCH_OFF || FETCH_OFF >= NPHASE) begin : g_param_err
    $error("phase_gen: illegal NPHASE/ALU_PHASE/FETCH_ON/FETCH_OFF combination");
  end

  typedef enum logic [1:0] {
    M_IDLE,
    M_RUN,
    M_BAD
  } mode_e;

  function automatic logic [NPHASE-1:0] fetch_window();
    logic [NPHASE-1:0] m;
    for (int i = 0; i < NPHASE; i++) begin
      m[i] = (i >= FETCH_ON) && (i <= FETCH_OFF);
    end
    return m;
  endfunction

  localparam logic [NPHASE-1:0] FETCH_MASK = fetch_window();
  localparam logic [NPHASE-1:0] PH_FIRST   = NPHASE'(1);

  logic [NPHASE-1:0] phase_q, phase_d;
  logic              pend_q, pend_d;
  logic              fetch_q, fetch_d;
  logic              alu_q, alu_d;
  logic              done_q, done_d;
  logic              idle_q, idle_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mode_e             mode;
  logic              last_ph;

  // All-zero is IDLE; any value with more than one bit set is a corrupted register.
  always_comb begin
    mode = M_RUN;
    if (phase_q == '0) begin
      mode = M_IDLE;
    end else if ((phase_q & (phase_q - PH_FIRST)) != '0) begin
      mode = M_BAD;
    end
  end

  assign last_ph = phase_q[NPHASE-1];

  always_comb begin
    phase_d = phase_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (mode)
      M_IDLE: begin
        pend_d = 1'b0;
        if (run && !halt) begin
          phase_d = PH_FIRST;
        end
      end
      M_BAD: begin
        phase_d = '0;
        pend_d  = 1'b0;
      end
      default: begin
        if (stall) begin
          pend_d = pend_q | halt;
        end else if (last_ph) begin
          // A halt arriving on the wrap edge still counts for this wrap.
          cnt_d  = cnt_q + CNT_W'(1);
          done_d = 1'b1;
          if (pend_q || halt) begin
            phase_d = '0;
            pend_d  = 1'b0;
          end else begin
            phase_d = PH_FIRST;
          end
        end else begin
          phase_d = phase_q << 1;
          pend_d  = pend_q | halt;
        end
      end
    endcase
    // Strobes are decoded from the next phase so they line up with the phase register.
    fetch_d = |(phase_d & FETCH_MASK);
    alu_d   = phase_d[ALU_PHASE];
    idle_d  = (phase_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      pend_q  <= 1'b0;
      fetch_q <= 1'b0;
      alu_q   <= 1'b0;
      done_q  <= 1'b0;
      idle_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      pend_q  <= pend_d;
      fetch_q <= fetch_d;
      alu_q   <= alu_d;
      done_q  <= done_d;
      idle_q  <= idle_d;
      cnt_q   <= cnt_d;
    end
  end

  assign phase      = phase_q;
  assign fetch      = fetch_q;
  assign alu_ena    = alu_q;
  assign cycle_done = done_q;
  assign idle       = idle_q;
  assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_phase_gen.sv
// Scoreboard bench for phase_gen: a phase-index model predicts each cycle's outputs,
// a monitor compares them; a CNT_W=4 instance shares the stimulus to show counter wrap.
module tb_phase_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        fetch, alu_ena, cycle_done, idle;
  logic [7:0]  phase;
  logic [15:0] cycle_cnt;
  logic        fetch4, alu_ena4, cycle_done4, idle4;
  logic [7:0]  phase4;
  logic [3:0]  cycle_cnt4;

  int n_total = 0;
  int n_pass  = 0;

  phase_gen dut (
    .clk(clk), .rst(rst), .run(run), .stall(stall), .halt(halt),
    .fetch(fetch), .alu_ena(alu_ena), .phase(phase), .cycle_done(cycle_done),
    .idle(idle), .cycle_cnt(cycle_cnt)
  );

  phase_gen #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .run(run), .stall(stall), .halt(halt),
    .fetch(fetch4), .alu_ena(alu_ena4), .phase(phase4), .cycle_done(cycle_done4),
    .idle(idle4), .cycle_cnt(cycle_cnt4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  phase;
    logic        fetch;
    logic        alu;
    logic        done;
    logic        idle;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: current phase index (-1 = idle), pending halt, completed cycles.
  int m_ph   = -1;
  bit m_pend = 0;
  int m_cnt  = 0;
  bit m_done = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
  endtask

  task automatic model_step(input bit r, input bit ru, input bit st, input bit ha);
    m_done = 0;
    if (r) begin
      m_ph = -1; m_pend = 0; m_cnt = 0;
    end else if (m_ph < 0) begin
      if (ru && !ha) m_ph = 0;
    end else if (st) begin
      m_pend = m_pend | ha;
    end else if (m_ph == 7) begin
      m_cnt  = m_cnt + 1;
      m_done = 1;
      if (m_pend || ha) begin
        m_ph = -1; m_pend = 0;
      end else begin
        m_ph = 0;
      end
    end else begin
      m_ph   = m_ph + 1;
      m_pend = m_pend | ha;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    logic [31:0] c;
    c       = m_cnt;
    e.phase = (m_ph < 0) ? 8'h00 : 8'(1 << m_ph);
    e.fetch = (m_ph >= 3) && (m_ph <= 6);
    e.alu   = (m_ph == 1);
    e.done  = m_done;
    e.idle  = (m_ph < 0);
    e.cnt   = c[15:0];
    e.cnt4  = c[3:0];
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit r, input bit ru, input bit st, input bit ha);
    @(negedge clk);
    rst = r; run = ru; stall = st; halt = ha;
    model_step(r, ru, st, ha);
    push_exp();
  endtask

  task automatic run_to(input int ph);
    for (int i = 0; i < 20 && m_ph != ph; i++) drive(0, 1, 0, 0);
  endtask

  // Corrupt both phase registers with two bits set; the machine must fall back to IDLE.
  task automatic corrupt_phase();
    @(negedge clk);
    rst = 0; run = 1; stall = 0; halt = 0;
    force dut.phase_q  = 8'b00000110;
    force dut4.phase_q = 8'b00000110;
    #1;
    release dut.phase_q;
    release dut4.phase_q;
    m_ph = -1; m_pend = 0; m_done = 0;
    push_exp();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("phase",      {24'd0, phase},      {24'd0, e.phase});
        chk("fetch",      {31'd0, fetch},      {31'd0, e.fetch});
        chk("alu_ena",    {31'd0, alu_ena},    {31'd0, e.alu});
        chk("cycle_done", {31'd0, cycle_done}, {31'd0, e.done});
        chk("idle",       {31'd0, idle},       {31'd0, e.idle});
        chk("cycle_cnt",  {16'd0, cycle_cnt},  {16'd0, e.cnt});
        chk("cnt4",       {28'd0, cycle_cnt4}, {28'd0, e.cnt4});
        chk("phase4",     {24'd0, phase4},     {24'd0, e.phase});
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) drive(0, 0, 0, 1);
    for (int i = 0; i < 24; i++) drive(0, 1, 0, 0);

    run_to(4);
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 0);

    run_to(2);
    drive(0, 1, 0, 1);
    for (int i = 0; i < 12 && m_ph >= 0; i++) drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 0);

    run_to(7);
    drive(0, 1, 1, 1);
    drive(0, 1, 1, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);

    drive(0, 1, 0, 0);
    run_to(5);
    drive(1, 1, 1, 1);
    drive(0, 0, 0, 0);

    drive(0, 1, 0, 0);
    for (int i = 0; i < 17 * 8 - 1; i++) drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);

    run_to(5);
    corrupt_phase();
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end

    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
